// File: rtl/lut4_pkg.sv
// ============================================================================
// Module : lut4_pkg
// Brief  : Operation and FSM state encodings shared by the LUT4 function unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut4_pkg;

    localparam logic [1:0] LUT4_OP_LO   = 2'b00;
    localparam logic [1:0] LUT4_OP_HI   = 2'b01;
    localparam logic [1:0] LUT4_OP_FULL = 2'b10;
    localparam logic [1:0] LUT4_OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        LUT4_ST_IDLE  = 2'd0,
        LUT4_ST_PASS2 = 2'd1,
        LUT4_ST_DONE  = 2'd2
    } lut4_state_e;

    // Only FULL spans both table halves and so needs two lookup passes.
    function automatic logic lut4_needs_pass2(input logic [1:0] op);
        return (op == LUT4_OP_FULL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut4_rv32.sv
// ============================================================================
// Module : lut4_rv32
// Brief  : One combinational lookup pass over eight index nibbles, selecting
//          from an eight-entry nibble table.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut4_rv32 #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            hi,
    output logic [XLEN-1:0] rd
);

    // Index bit 3 picks the table half; entries from the other half yield 0.
    for (genvar i = 0; i < XLEN / 4; i++) begin : g_nib
        logic [3:0] w_nib;
        logic [2:0] w_idx;
        logic       w_sel;
        logic [4:0] w_base;

        assign w_nib  = rs1[4*i +: 4];
        assign w_idx  = w_nib[2:0];
        assign w_sel  = w_nib[3];
        assign w_base = {w_idx, 2'b00};
        assign rd[4*i +: 4] = (w_sel == hi) ? rs2[w_base +: 4] : 4'h0;
    end

endmodule

`default_nettype wire

// File: rtl/lut4_fu.sv
// ============================================================================
// Module : lut4_fu
// Brief  : Handshaked 4-bit nibble lookup unit (LO / HI / FULL ops).
//          LUT4_FU_DUALCORE_EN: two lookup cores finish FULL in one pass.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut4_fu
    import lut4_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd
);

    lut4_state_e     state_q;
    logic [XLEN-1:0] rd_q;
    logic            w_accept;
    logic [XLEN-1:0] w_accept_rd;

    assign in_ready  = (state_q == LUT4_ST_IDLE) ||
                       ((state_q == LUT4_ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == LUT4_ST_DONE);
    assign out_rd    = rd_q;

`ifdef LUT4_FU_DUALCORE_EN

    logic [XLEN-1:0] w_lo_rd;
    logic [XLEN-1:0] w_hi_rd;

    lut4_rv32 #(.XLEN(XLEN)) u_core_lo (
        .rs1 (in_rs1),
        .rs2 (in_rs2),
        .hi  (1'b0),
        .rd  (w_lo_rd)
    );

    lut4_rv32 #(.XLEN(XLEN)) u_core_hi (
        .rs1 (in_rs1),
        .rs2 (in_rs3),
        .hi  (1'b1),
        .rd  (w_hi_rd)
    );

    always_comb begin
        w_accept_rd = '0;
        case (in_op)
            LUT4_OP_LO:   w_accept_rd = w_lo_rd;
            LUT4_OP_HI:   w_accept_rd = w_hi_rd;
            LUT4_OP_FULL: w_accept_rd = w_lo_rd | w_hi_rd;
            default:      w_accept_rd = '0;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= LUT4_ST_IDLE;
            rd_q    <= '0;
        end else begin
            case (state_q)
                LUT4_ST_IDLE, LUT4_ST_DONE: begin
                    if (w_accept) begin
                        state_q <= LUT4_ST_DONE;
                        rd_q    <= w_accept_rd;
                    end else if (state_q == LUT4_ST_DONE && out_ready) begin
                        state_q <= LUT4_ST_IDLE;
                    end
                end
                default: state_q <= LUT4_ST_IDLE;
            endcase
        end
    end

`else

    // Pass 2 of FULL works from the operands captured at acceptance.
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs3_q;
    logic [XLEN-1:0] pass1_q;
    logic [XLEN-1:0] w_core_rs1;
    logic [XLEN-1:0] w_core_tbl;
    logic            w_core_hi;
    logic [XLEN-1:0] w_core_rd;
    logic            w_in_pass2;

    assign w_in_pass2 = (state_q == LUT4_ST_PASS2);
    assign w_core_rs1 = w_in_pass2 ? rs1_q : in_rs1;
    assign w_core_tbl = w_in_pass2 ? rs3_q :
                        ((in_op == LUT4_OP_HI) ? in_rs3 : in_rs2);
    assign w_core_hi  = w_in_pass2 || (in_op == LUT4_OP_HI);

    lut4_rv32 #(.XLEN(XLEN)) u_core (
        .rs1 (w_core_rs1),
        .rs2 (w_core_tbl),
        .hi  (w_core_hi),
        .rd  (w_core_rd)
    );

    assign w_accept_rd = (in_op == LUT4_OP_RSVD) ? '0 : w_core_rd;

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= LUT4_ST_IDLE;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs3_q   <= '0;
            pass1_q <= '0;
        end else begin
            case (state_q)
                LUT4_ST_PASS2: begin
                    rd_q    <= pass1_q | w_core_rd;
                    state_q <= LUT4_ST_DONE;
                end
                LUT4_ST_IDLE, LUT4_ST_DONE: begin
                    if (w_accept) begin
                        if (lut4_needs_pass2(in_op)) begin
                            state_q <= LUT4_ST_PASS2;
                            pass1_q <= w_core_rd;
                            rs1_q   <= in_rs1;
                            rs3_q   <= in_rs3;
                        end else begin
                            state_q <= LUT4_ST_DONE;
                            rd_q    <= w_accept_rd;
                        end
                    end else if (state_q == LUT4_ST_DONE && out_ready) begin
                        state_q <= LUT4_ST_IDLE;
                    end
                end
                default: state_q <= LUT4_ST_IDLE;
            endcase
        end
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_lut4_fu.sv
// ============================================================================
// Module : tb_lut4_fu
// Brief  : Scoreboard bench for lut4_fu (honours LUT4_FU_DUALCORE_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut4_fu;

    logic        g_clk = 1'b0;
    logic        g_rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_rs3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb[$];

    always #5 g_clk = ~g_clk;

    lut4_fu #(.XLEN(32)) dut (
        .g_clk     (g_clk),
        .g_rst     (g_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rs3    (in_rs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd)
    );

    // Reference: a 16-entry nibble table = {rs3, rs2}, masked by op.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        logic [31:0] r;
        logic [63:0] tbl;
        int          n;
        r   = 32'h0;
        tbl = {c, b};
        for (int i = 0; i < 8; i++) begin
            n = int'(a[4*i +: 4]);
            if ((op == 2'b10) || (op == 2'b00 && n < 8) || (op == 2'b01 && n >= 8))
                r[4*i +: 4] = tbl[4*n +: 4];
        end
        return r;
    endfunction

    always @(negedge g_clk) begin
        if (g_rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got out_rd=%h, expected no result", out_rd);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (out_rd !== e) begin
                    n_err++;
                    $display("FAIL sb_rd: got %h, expected %h", out_rd, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic drive(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rs3   = c;
        @(negedge g_clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge g_clk);
            t++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_timeout: got in_ready=%b, expected 1", in_ready);
        end else begin
            sb.push_back(model(op, a, b, c));
        end
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_rs3   = $urandom;
    endtask

    task automatic test_reset();
        g_rst     = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_rs1    = 32'h76543210;
        in_rs2    = 32'hFEDCBA98;
        in_rs3    = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge g_clk);
        #1;
        g_rst    = 1'b0;
        in_valid = 1'b0;
        @(negedge g_clk);
        n_vec += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_ready: got %b, expected 1", in_ready); end
        if (out_rd !== 32'h0)   begin n_err++; $display("FAIL rst_rd: got %h, expected 0", out_rd); end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_lo();
        out_ready = 1'b1;
        drive(2'b00, 32'h76543210, 32'hFEDCBA98, 32'h13579BDF);
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_rd !== 32'hFEDCBA98) begin
            n_err++;
            $display("FAIL lo: got valid=%b rd=%h, expected valid=1 rd=fedcba98", out_valid, out_rd);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_hi();
        out_ready = 1'b1;
        drive(2'b01, 32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF);
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_rd !== 32'h0) begin
            n_err++;
            $display("FAIL hi: got valid=%b rd=%h, expected valid=1 rd=00000000", out_valid, out_rd);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        drive(2'b10, 32'hFEDCBA98, 32'h01234567, 32'h89ABCDEF);
`ifndef LUT4_FU_DUALCORE_EN
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_early: got out_valid=%b, expected 0", out_valid);
        end
        @(posedge g_clk);
        #1;
`endif
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_rd !== 32'h89ABCDEF) begin
            n_err++;
            $display("FAIL full: got valid=%b rd=%h, expected valid=1 rd=89abcdef", out_valid, out_rd);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_rsvd();
        out_ready = 1'b1;
        drive(2'b11, $urandom, $urandom, $urandom);
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_rd !== 32'h0) begin
            n_err++;
            $display("FAIL rsvd: got valid=%b rd=%h, expected valid=1 rd=00000000", out_valid, out_rd);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c, la, lb, held;
        a  = $urandom; b = $urandom; c = $urandom;
        la = $urandom; lb = $urandom;
        held = model(2'b10, a, b, c);
        out_ready = 1'b0;
        drive(2'b10, a, b, c);
`ifndef LUT4_FU_DUALCORE_EN
        @(posedge g_clk);
        #1;
`endif
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_rs1   = la;
        in_rs2   = lb;
        in_rs3   = $urandom;
        for (int k = 0; k < 5; k++) begin
            @(negedge g_clk);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rd !== held) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b rd=%h, expected valid=1 ready=0 rd=%h",
                         k, out_valid, in_ready, out_rd, held);
            end
            @(posedge g_clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge g_clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got in_ready=%b, expected 1", in_ready);
        end
        sb.push_back(model(2'b00, la, lb, 32'h0));
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_lo_latency: got out_valid=%b, expected 1", out_valid);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset_pass2();
        out_ready = 1'b0;
        drive(2'b10, 32'hFEDCBA98, 32'h01234567, 32'h89ABCDEF);
        void'(sb.pop_back());
        g_rst = 1'b1;
        @(posedge g_clk);
        #1;
        g_rst = 1'b0;
        @(negedge g_clk);
        n_vec += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstp2_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rstp2_ready: got %b, expected 1", in_ready); end
        if (out_rd !== 32'h0)   begin n_err++; $display("FAIL rstp2_rd: got %h, expected 0", out_rd); end
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rstp2_ghost[%0d]: got out_valid=%b, expected 0", k, out_valid);
            end
        end
        @(posedge g_clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = $urandom;
            in_op  = 2'b00;
            in_rs1 = a;
            in_rs2 = b;
            in_rs3 = $urandom;
            @(negedge g_clk);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %b, expected 1", k, in_ready);
            end
            if (k > 0) begin
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_bubble[%0d]: got out_valid=%b, expected 1", k, out_valid);
                end
            end
            sb.push_back(model(2'b00, a, b, 32'h0));
            @(posedge g_clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge g_clk);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_last: got out_valid=%b, expected 1", out_valid);
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_random();
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge g_clk);
                #1;
            end
        end
        repeat (4) @(posedge g_clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
    endtask

    initial begin
        g_rst     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_rs1    = 32'h0;
        in_rs2    = 32'h0;
        in_rs3    = 32'h0;
        out_ready = 1'b1;
        test_reset();
        test_lo();
        test_hi();
        test_full();
        test_rsvd();
        test_backpressure();
        test_reset_pass2();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut4_fu.md
LUT4_FU -- requirements
Module: lut4_fu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width (32 is the only legal value).
REQ-002 SHALL have port g_clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port g_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_op  input  2  operation: 00 LO, 01 HI, 10 FULL, 11 reserved.
REQ-007 SHALL have port in_rs1  input  XLEN  index nibbles.
REQ-008 SHALL have port in_rs2  input  XLEN  table entries 0-7 (one nibble each).
REQ-009 SHALL have port in_rs3  input  XLEN  table entries 8-15 (used by HI and FULL).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port out_rd  output  XLEN  result.

Function
REQ-013 SHALL define the per-nibble lookup as: for nibble i, idx = rs1.4[i] bits 2:0, sel = rs1.4[i] bit 3; the pass result is 0 when sel != hi, otherwise table.4[idx].
REQ-014 LO SHALL perform one lookup pass with hi=0 and table=in_rs2.
REQ-015 HI SHALL perform one lookup pass with hi=1 and table=in_rs3.
REQ-016 FULL SHALL perform pass 1 (hi=0, in_rs2) and pass 2 (hi=1, in_rs3), and out_rd SHALL be pass1 OR pass2; this is a 16-entry nibble lookup.
REQ-017 Reserved op SHALL complete like LO but with out_rd = 0.
REQ-018 SHALL capture in_op, in_rs1 and in_rs3 on acceptance; later changes to the inputs SHALL NOT affect an accepted request.
REQ-019 The FSM SHALL have the states IDLE, PASS2 and DONE.
REQ-020 FSM transitions:
  - IDLE -> DONE on acceptance of LO/HI/reserved.
  - IDLE -> PASS2 on acceptance of FULL.
  - PASS2 -> DONE unconditionally.
  - DONE -> IDLE on out_ready, unless a new request is accepted in the same cycle (then the IDLE rules apply).
REQ-021 in_ready SHALL be (state==IDLE) || (state==DONE && out_ready).
REQ-022 out_valid SHALL be 1 exactly in DONE.
REQ-023 out_rd SHALL be registered and SHALL be stable while out_valid && !out_ready.
REQ-024 Latency from the acceptance edge to out_valid: 1 cycle for LO/HI/reserved, 2 cycles for FULL.
REQ-025 Throughput with out_ready held high: one LO/HI per cycle; one FULL per 2 cycles.
REQ-026 out_rd SHALL hold its last value while not in DONE; the bench SHALL ignore it there.

Reset
REQ-027 On g_rst: state=IDLE, out_valid=0, out_rd=0, and in_ready=1 from the first cycle after reset.
REQ-028 Reset asserted mid-operation (PASS2 or DONE) SHALL discard the request with no output handshake.
REQ-029 in_valid SHALL be ignored in any cycle g_rst is high.

Configuration
REQ-030 Macro LUT4_FU_DUALCORE_EN:
  - Defined: two lookup cores evaluate both passes in one cycle; FULL goes IDLE -> DONE with 1-cycle latency; PASS2 is unreachable.
  - Undefined: a single core is time-shared across passes per REQ-016/REQ-024.
  - Results SHALL be identical in both builds.

Structure
REQ-031 A shared package lut4_pkg SHALL hold the op encodings (LUT4_OP_LO/HI/FULL/RSVD) and the FSM state encodings.
REQ-032 The per-pass lookup SHALL be the existing combinational sub-module lut4_rv32 (rs1, rs2 table, hi -> rd), instantiated once (twice under LUT4_FU_DUALCORE_EN).
REQ-033 The pass-1 result SHALL be held in an internal register between PASS2 and DONE.

Verification
REQ-034 LO: rs1=0x76543210, rs2=0xFEDCBA98, out_ready=1 -> out_rd=0xFEDCBA98 one cycle after acceptance.
REQ-035 FULL: rs1=0xFEDCBA98, rs2=0x01234567, rs3=0x89ABCDEF -> out_rd=0x89ABCDEF two cycles after acceptance (one cycle with DUALCORE).
REQ-036 HI with rs1=0x76543210 -> out_rd=0x00000000.
REQ-037 Back-pressure: FULL result with out_ready=0 for 5 cycles -> out_valid and out_rd held, in_ready=0; the cycle out_ready=1, a queued LO is accepted, and its result appears on the next cycle.
REQ-038 Reset in PASS2: the next cycle shows out_valid=0, in_ready=1, out_rd=0; no result for the discarded request.
REQ-039 Reserved op 11 with any operands -> out_rd=0 after 1 cycle; back-to-back LO stream at 1 result per cycle with no bubbles.
